des_key_generator: RTL and testbench
====================================

# des_key_generator

Sequential DES key schedule. Stands directly upstream of the S-box stage: it produces the 48-bit round key that is XORed with the expanded right half to form the 6-bit S-box input segments. From one 64-bit key, it emits the 16 round keys in encrypt order (K1..K16) or decrypt order (K16..K1), one key per accepted advance.

## Interface
- No parameters. Widths are fixed by DES.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start_strobe_din`  in  1  loads a new key. Accepted only in IDLE.
- `enc_dec_din`  in  1  0 = encrypt order, 1 = decrypt order. Sampled with start.
- `key_din`  in  [0:63]  DES key. Bit 0 is DES bit 1 (MSB). Parity bits 7, 15, …, 63 are ignored.
- `advance_din`  in  1  consumer has taken the current round key.
- `round_key_dout`  out  [0:47]  current round key. Bits [0:5] feed S-box 1, bits [6:11] feed S-box 2, and so on.
- `round_key_valid_dout`  out  1  `round_key_dout` holds a valid key.
- `round_count_dout`  out  [3:0]  sequence index 0..15 of the presented key.
- `last_key_dout`  out  1  high while the 16th key is presented.
- `busy_dout`  out  1  high in ACTIVE.

## Operation
- Internal state: registers C[0:27] and D[0:27], a 4-bit counter, a direction flag, and an FSM with two states.
- **FSM states**
  - IDLE: valid = 0, busy = 0.
  - ACTIVE: valid = 1, busy = 1.
- **IDLE → ACTIVE** on `start_strobe_din`.
  - C/D ← PC1(`key_din`), pre-shifted for the first key.
  - Encrypt: rotate left by 1, giving C1/D1.
  - Decrypt: no shift, since C16 = C0.
  - Counter ← 0. Direction flag ← `enc_dec_din`.
- **ACTIVE, `advance_din` = 1, counter < 15:** counter + 1, and C/D step to the next key.
  - Encrypt: rotate left by shift[next round].
  - Decrypt: rotate right by shift[current round].
  - shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Current DES round index: encrypt = counter + 1; decrypt = 16 − counter.
- **ACTIVE, `advance_din` = 1, counter = 15:** go to IDLE.
- **ACTIVE, `advance_din` = 0:** hold all state. The key stays stable.
- `round_key_dout` = PC2(C‖D), combinational from registers, so glitch-free relative to `clk`.
- `last_key_dout` = ACTIVE and counter = 15.
- `advance_din` in IDLE is ignored.
- `start_strobe_din` in ACTIVE is ignored, including in the cycle the final key is consumed. A new start is accepted no earlier than the following cycle.
- `enc_dec_din` and `key_din` are don't-care except in the start cycle.

## Timing
- **Reset** (any state, including mid-sequence): next edge gives FSM = IDLE, C = D = 0, counter = 0, direction = 0.
  - Output values after reset: `round_key_dout` = 0, `round_key_valid_dout` = 0, `round_count_dout` = 0, `last_key_dout` = 0, `busy_dout` = 0.
  - Reset dominates start and advance in the same cycle.
- **Latency:** start accepted at edge t → first key valid after edge t.
- **Throughput:** one key per cycle with `advance_din` held high.
  - Full 16-key sequence: 16 cycles.
  - Start-to-start minimum: 17 cycles.
- **Handshake:** a key transfers on a rising edge where valid = 1 and advance = 1. The next key appears after that edge.

## Structure
- Shared package `des_pkg` holds:
  - PC1 table (56 entries) and PC2 table (48 entries), as bit-index constants.
  - Shift schedule constant.
  - Encrypt/decrypt encoding constants.
  - FSM state typedef.
- One natural sub-module: `des_key_pc2`. It is a combinational PC2 permutation from the 56-bit C‖D to the 48-bit key, reused by any unrolled core.
- The PC1 permutation and the rotators stay inline in this block.

## Test plan
- **Reset values:** assert reset for 2 cycles → every output 0, busy = 0.
- **Encrypt sequence:** key 0x133457799BBCDFF1, encrypt, advance held high.
  - Cycle 1: `round_key_dout` = 0x1B02EFFC7072 (K1), count 0.
  - Cycle 16: 0xCB3D8B0E17F5 (K16), last = 1.
  - Then valid = 0.
- **Decrypt sequence:** same key, decrypt → first key 0xCB3D8B0E17F5, last key 0x1B02EFFC7072. The full 16-key sequence equals the encrypt sequence reversed.
- **Stall:** advance low for 5 cycles at count 7 → key and count hold for exactly those cycles. The sequence then resumes with K9 (encrypt).
- **Protocol:**
  - Start while busy at count 3 → ignored; the sequence continues unchanged.
  - Start coincident with the final advance → ignored.
  - Start on the next cycle → accepted.
- **Reset mid-sequence:** reset at count 10 → IDLE with outputs 0 on the next edge. A subsequent start begins again from K1.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, shift schedule, direction codes and FSM states
package des_pkg;
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  // bit r-1 set when DES round r rotates by two instead of one
  localparam logic [0:15] SHIFT2 = 16'b0011_1111_0111_1110;
  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/des_key_pc2.sv
// des_key_pc2: combinational PC2 selection of the 48-bit round key from C||D
module des_key_pc2
  import des_pkg::*;
(
  input  logic [0:55] i_cd,
  output logic [0:47] o_key
);
  logic w_unused_dropped;
  genvar j;
  for (j = 0; j < 48; j++) begin : g_pc2
    assign o_key[j] = i_cd[PC2_TAB[j]-1];
  end
  assign w_unused_dropped = ^{i_cd[8], i_cd[17], i_cd[21], i_cd[24],
                              i_cd[34], i_cd[37], i_cd[42], i_cd[53]};
endmodule

// File: rtl/des_key_generator.sv
// des_key_generator: sequential DES key schedule emitting K1..K16 or K16..K1 one per advance
module des_key_generator
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_strobe_din,
  input  logic        enc_dec_din,
  input  logic [0:63] key_din,
  input  logic        advance_din,
  output logic [0:47] round_key_dout,
  output logic        round_key_valid_dout,
  output logic [3:0]  round_count_dout,
  output logic        last_key_dout,
  output logic        busy_dout
);
  state_t      r_state, w_next_state;
  logic [0:27] r_c, r_d, w_c_step, w_d_step;
  logic [0:55] w_pc1;
  logic [3:0]  r_cnt;
  logic        r_dir, w_start, w_adv, w_two, w_unused_parity;
  genvar i;
  for (i = 0; i < 56; i++) begin : g_pc1
    assign w_pc1[i] = key_din[PC1_TAB[i]-1];
  end
  assign w_unused_parity = ^{key_din[7], key_din[15], key_din[23], key_din[31],
                             key_din[39], key_din[47], key_din[55], key_din[63]};
  // decrypt walks backwards, undoing the shift of the round it is leaving
  always_comb begin
    w_start      = r_state == ST_IDLE && start_strobe_din;
    w_adv        = r_state == ST_ACTIVE && advance_din;
    w_next_state = w_start ? ST_ACTIVE : (w_adv && r_cnt == 4'd15) ? ST_IDLE : r_state;
    w_two        = r_dir == DIR_DEC ? SHIFT2[4'd15 - r_cnt] : SHIFT2[r_cnt + 4'd1];
    w_c_step     = r_dir == DIR_DEC ? (w_two ? {r_c[26:27], r_c[0:25]} : {r_c[27], r_c[0:26]})
                                    : (w_two ? {r_c[2:27], r_c[0:1]} : {r_c[1:27], r_c[0]});
    w_d_step     = r_dir == DIR_DEC ? (w_two ? {r_d[26:27], r_d[0:25]} : {r_d[27], r_d[0:26]})
                                    : (w_two ? {r_d[2:27], r_d[0:1]} : {r_d[1:27], r_d[0]});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dir   <= DIR_ENC;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_c   <= enc_dec_din == DIR_DEC ? w_pc1[0:27] : {w_pc1[1:27], w_pc1[0]};
        r_d   <= enc_dec_din == DIR_DEC ? w_pc1[28:55] : {w_pc1[29:55], w_pc1[28]};
        r_cnt <= '0;
        r_dir <= enc_dec_din;
      end else if (w_adv && r_cnt != 4'd15) begin
        r_c   <= w_c_step;
        r_d   <= w_d_step;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
  des_key_pc2 u_pc2 (.i_cd({r_c, r_d}), .o_key(round_key_dout));
  assign round_key_valid_dout = r_state == ST_ACTIVE;
  assign busy_dout            = r_state == ST_ACTIVE;
  assign round_count_dout     = r_cnt;
  assign last_key_dout        = r_state == ST_ACTIVE && r_cnt == 4'd15;
endmodule

// File: tb/tb_des_key_generator.sv
// tb_des_key_generator: directed and randomized checks against a textbook DES key-schedule model
module tb_des_key_generator;
  logic        clk = 1'b0;
  logic        reset, start_strobe_din, enc_dec_din, advance_din;
  logic [0:63] key_din;
  logic [0:47] round_key_dout;
  logic        round_key_valid_dout, last_key_dout, busy_dout;
  logic [3:0]  round_count_dout;
  int vectors = 0, miscompares = 0;
  logic [47:0] rk [1:16];
  localparam logic [63:0] TV_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [47:0] TV_K1  = 48'h1B02_EFFC_7072;
  localparam logic [47:0] TV_K16 = 48'hCB3D_8B0E_17F5;
  localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
    19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,
    21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 clk = ~clk;

  des_key_generator dut (
    .clk(clk), .reset(reset), .start_strobe_din(start_strobe_din), .enc_dec_din(enc_dec_din),
    .key_din(key_din), .advance_din(advance_din), .round_key_dout(round_key_dout),
    .round_key_valid_dout(round_key_valid_dout), .round_count_dout(round_count_dout),
    .last_key_dout(last_key_dout), .busy_dout(busy_dout)
  );

  task automatic gen(input logic [0:63] k);
    logic [0:27] c, d;
    logic [0:55] cd;
    for (int i = 0; i < 28; i++) begin
      c[i] = k[PC1[i]-1];
      d[i] = k[PC1[i+28]-1];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SH[r-1]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) rk[r][47-j] = cd[PC2[j]-1];
    end
  endtask

  function automatic logic [47:0] expk(input bit dir, input int n);
    return dir ? rk[16-n] : rk[n+1];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [47:0] k, input int n, input bit v, input bit l);
    chk({tag, "_key"}, 64'(round_key_dout), 64'(k));
    chk({tag, "_cnt"}, 64'(round_count_dout), 64'(n));
    chk({tag, "_valid"}, 64'(round_key_valid_dout), 64'(v));
    chk({tag, "_busy"}, 64'(busy_dout), 64'(v));
    chk({tag, "_last"}, 64'(last_key_dout), 64'(l));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start(input logic [63:0] k, input bit dir);
    key_din = k;
    enc_dec_din = dir;
    start_strobe_din = 1'b1;
    tick;
    start_strobe_din = 1'b0;
    key_din = {$urandom, $urandom};
    enc_dec_din = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] k;
    bit d;
    int n, cyc;
    reset = 1'b1; start_strobe_din = 1'b0; enc_dec_din = 1'b0; advance_din = 1'b0; key_din = '0;
    tick; tick;
    chk_state("reset", 48'h0, 0, 0, 0);
    reset = 1'b0;
    gen(TV_KEY);
    start(TV_KEY, 1'b0);
    advance_din = 1'b1;
    chk("tv_k1", 64'(round_key_dout), 64'(TV_K1));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("tv_k16", 64'(round_key_dout), 64'(TV_K16));
      chk_state("enc", expk(1'b0, i), i, 1, i == 15);
      tick;
    end
    chk_state("enc_done", rk[16], 15, 0, 0);
    tick;
    chk("idle_adv_ignored", 64'(round_key_valid_dout), 64'd0);
    start(TV_KEY, 1'b1);
    chk("tv_dec_first", 64'(round_key_dout), 64'(TV_K16));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("tv_dec_last", 64'(round_key_dout), 64'(TV_K1));
      chk_state("dec", expk(1'b1, i), i, 1, i == 15);
      tick;
    end
    chk("dec_done_valid", 64'(round_key_valid_dout), 64'd0);
    repeat (8) begin
      k = {$urandom, $urandom};
      d = 1'($urandom);
      gen(k);
      advance_din = 1'b0;
      start(k, d);
      n = 0; cyc = 0;
      while (n < 16 && cyc < 200) begin
        chk_state(d ? "rnd_dec" : "rnd_enc", expk(d, n), n, 1, n == 15);
        advance_din = $urandom_range(0, 3) != 0;
        if (advance_din) n++;
        tick;
        cyc++;
      end
      chk("rnd_len", 64'(n), 64'd16);
      chk("rnd_done_valid", 64'(round_key_valid_dout), 64'd0);
    end
    gen(TV_KEY);
    start(TV_KEY, 1'b0);
    advance_din = 1'b1;
    repeat (7) tick;
    advance_din = 1'b0;
    repeat (5) begin
      chk_state("stall", rk[8], 7, 1, 0);
      tick;
    end
    advance_din = 1'b1;
    chk_state("stall_end", rk[8], 7, 1, 0);
    tick;
    chk_state("stall_resume", rk[9], 8, 1, 0);
    repeat (8) tick;
    chk("stall_tail_valid", 64'(round_key_valid_dout), 64'd0);
    k = {$urandom, $urandom};
    gen(TV_KEY);
    start(TV_KEY, 1'b0);
    repeat (3) tick;
    key_din = k; enc_dec_din = 1'b1; start_strobe_din = 1'b1;
    chk_state("busy_start", rk[4], 3, 1, 0);
    tick;
    start_strobe_din = 1'b0;
    chk_state("busy_start_ignored", rk[5], 4, 1, 0);
    repeat (11) tick;
    chk_state("final_key", rk[16], 15, 1, 1);
    key_din = k; enc_dec_din = 1'b1; start_strobe_din = 1'b1;
    tick;
    start_strobe_din = 1'b0;
    chk("final_start_ignored", 64'(round_key_valid_dout), 64'd0);
    gen(k);
    start(k, 1'b1);
    chk_state("next_start", rk[16], 0, 1, 0);
    repeat (4) tick;
    gen(TV_KEY);
    advance_din = 1'b0;
    repeat (12) tick;
    advance_din = 1'b1;
    repeat (12) tick;
    start(TV_KEY, 1'b0);
    repeat (10) tick;
    chk_state("pre_reset", rk[11], 10, 1, 0);
    reset = 1'b1; start_strobe_din = 1'b1;
    tick;
    reset = 1'b0; start_strobe_din = 1'b0;
    chk_state("mid_reset", 48'h0, 0, 0, 0);
    start(TV_KEY, 1'b0);
    chk_state("after_reset", TV_K1, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
